reg_file_sb: RTL and testbench

- Parametrised successor of the CPU general-purpose register file.
- Two combinational read ports, one synchronous write port, hardwired zero register, asynchronous clear.
- Adds a per-register pending-write scoreboard so the decode stage can stall on operands owned by in-flight multicycle producers.
- Sits between decode (read/issue side) and writeback (write side) of the pipelined datapath.

---
 rtl/reg_file_sb.sv | 85 ++++++++
 tb/tb_reg_file_sb.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port, a hardwired zero register
// and a pending-write scoreboard. Define REGFILE_BYPASS_EN to forward write data to the read ports.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] rn1_i,
    input  logic [ADDR_W-1:0] rn2_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic              busy1_o,
    output logic              busy2_o,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] wn_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic              set_busy_i,
    input  logic [ADDR_W-1:0] busy_n_i,
    output logic [ADDR_W:0]   busy_cnt_o
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
    logic              wr_eff, set_eff;
    logic              fwd_a, fwd_b;

    assign wr_eff  = write_i && (wn_i != '0);
    assign set_eff = set_busy_i && (busy_n_i != '0);

    // A set of the register being written this cycle wins: the new producer owns it.
    always_comb begin
        busy_d     = busy_q;
        busy_cnt_d = busy_cnt_q;
        if (wr_eff && busy_q[wn_i] && !(set_eff && (busy_n_i == wn_i))) begin
            busy_d[wn_i] = 1'b0;
            busy_cnt_d   = busy_cnt_d - CNT_ONE;
        end
        if (set_eff && !busy_q[busy_n_i]) begin
            busy_d[busy_n_i] = 1'b1;
            busy_cnt_d       = busy_cnt_d + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (wr_eff) regs_q[wn_i] <= wd_i;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign fwd_a = wr_eff && (wn_i == rn1_i);
    assign fwd_b = wr_eff && (wn_i == rn2_i);
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    always_comb begin
        a_o     = '0;
        b_o     = '0;
        busy1_o = 1'b0;
        busy2_o = 1'b0;
        if (rn1_i != '0) begin
            a_o     = fwd_a ? wd_i : regs_q[rn1_i];
            busy1_o = !fwd_a && busy_q[rn1_i];
        end
        if (rn2_i != '0) begin
            b_o     = fwd_b ? wd_i : regs_q[rn2_i];
            busy2_o = !fwd_b && busy_q[rn2_i];
        end
    end

    assign busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed plan items plus random traffic
// checked against an array/popcount model of the register file and scoreboard.
module tb_reg_file_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rn1, rn2, wn, bn;
    logic [DW-1:0] a, b, wd;
    logic          busy1, busy2, wr, setb;
    logic [AW:0]   cnt;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .rn1_i(rn1), .rn2_i(rn2), .a_o(a), .b_o(b),
        .busy1_o(busy1), .busy2_o(busy2), .write_i(wr), .wn_i(wn), .wd_i(wd),
        .set_busy_i(setb), .busy_n_i(bn), .busy_cnt_o(cnt)
    );

    logic [DW-1:0] m_mem  [NR];
    bit            m_busy [NR];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic bit m_fwd(input logic [AW-1:0] rn);
`ifdef REGFILE_BYPASS_EN
        return wr && (wn != 0) && (wn == rn);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] rn);
        if (rn == 0) return '0;
        if (m_fwd(rn)) return wd;
        return m_mem[rn];
    endfunction

    function automatic bit m_bz(input logic [AW-1:0] rn);
        if (rn == 0 || m_fwd(rn)) return 1'b0;
        return m_busy[rn];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".A"},     a,     m_rd(rn1));
        check({tag, ".B"},     b,     m_rd(rn2));
        check({tag, ".Busy1"}, busy1, m_bz(rn1));
        check({tag, ".Busy2"}, busy2, m_bz(rn2));
        check({tag, ".cnt"},   cnt,   m_count());
    endtask

    // One clock cycle: drive after the falling edge, check pre-edge view, then advance the model.
    task automatic step(input string tag, input bit w, input int wa, input logic [DW-1:0] d,
                        input bit s, input int sa, input int r1, input int r2);
        @(negedge clk);
        wr = w; wn = AW'(wa); wd = d; setb = s; bn = AW'(sa);
        rn1 = AW'(r1); rn2 = AW'(r2);
        #1;
        check_outputs(tag);
        @(posedge clk);
        if (w && wa != 0) begin
            m_mem[wa]  = d;
            m_busy[wa] = 1'b0;
        end
        if (s && sa != 0) m_busy[sa] = 1'b1;
    endtask

    task automatic idle(input string tag, input int r1, input int r2);
        step(tag, 1'b0, 0, '0, 1'b0, 0, r1, r2);
    endtask

    initial begin
        rst_n = 1'b0;
        wr = 0; wn = 0; wd = 0; setb = 0; bn = 0; rn1 = 0; rn2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset: preload, then mid-cycle async reset
        step("pre_r5", 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 5, 7);
        step("pre_b7", 1'b0, 0, '0, 1'b1, 7, 5, 7);
        idle("pre_chk", 5, 7);
        @(negedge clk);
        rn1 = 5; rn2 = 7;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst.A_r5", a, 32'h0);
        check("rst.Busy2_r7", busy2, 1'b0);
        check("rst.cnt", cnt, 0);
        rn1 = 7;
        #1 check("rst.Busy1_r7", busy1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero register
        step("z_wr", 1'b1, 0, 32'h12345678, 1'b0, 0, 0, 0);
        step("z_set", 1'b0, 0, '0, 1'b1, 0, 0, 0);
        idle("z_chk", 0, 0);
        check("z.A_lit", a, 32'h0);

        // Scoreboard
        step("sb_s3", 1'b0, 0, '0, 1'b1, 3, 3, 4);
        step("sb_s4", 1'b0, 0, '0, 1'b1, 4, 3, 4);
        idle("sb_chk", 3, 4);
        check("sb.cnt2", cnt, 2);
        check("sb.busy_r3", busy1, 1'b1);
        step("sb_w3", 1'b1, 3, 32'h55, 1'b0, 0, 3, 4);
        idle("sb_chk2", 3, 4);
        check("sb.A_r3", a, 32'h55);
        check("sb.cnt1", cnt, 1);

        // Same-register collision: set wins, data written
        step("col_s9", 1'b0, 0, '0, 1'b1, 9, 9, 9);
        step("col_ws9", 1'b1, 9, 32'hAA, 1'b1, 9, 9, 9);
        idle("col_chk", 9, 0);
        check("col.A", a, 32'hAA);
        check("col.busy", busy1, 1'b1);
        check("col.cnt", cnt, 2);

        // Bypass window (expected values depend on REGFILE_BYPASS_EN in the model)
        step("byp_s6", 1'b0, 0, '0, 1'b1, 6, 6, 6);
        step("byp_w6", 1'b1, 6, 32'h0F0F, 1'b0, 0, 6, 6);
        idle("byp_chk", 6, 6);
        check("byp.A_post", a, 32'h0F0F);

        // Full sweep
        for (int i = 1; i < NR; i++) step("sw_set", 1'b0, 0, '0, 1'b1, i, i, 0);
        step("sw_again", 1'b0, 0, '0, 1'b1, 17, 17, 1);
        idle("sw_full", 1, 31);
        check("sw.cnt31", cnt, 31);
        for (int i = 1; i < NR; i++) step("sw_wr", 1'b1, i, DW'(32'hA500_0000 + i), 1'b0, 0, i, NR - i);
        idle("sw_empty", 1, 2);
        check("sw.cnt0", cnt, 0);
        for (int i = 1; i < NR; i++) idle("sw_rd", i, (i * 7) % NR);

        // Random traffic, biased towards collisions between ports
        for (int k = 0; k < 600; k++) begin
            int wa, sa, r1, r2;
            wa = $urandom_range(NR - 1);
            sa = ($urandom_range(3) == 0) ? wa : $urandom_range(NR - 1);
            r1 = ($urandom_range(2) == 0) ? wa : $urandom_range(NR - 1);
            r2 = ($urandom_range(2) == 0) ? sa : $urandom_range(NR - 1);
            step("rnd", 1'($urandom_range(1)), wa, $urandom, 1'($urandom_range(1)), sa, r1, r2);
        end
        idle("rnd_end", 1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
